alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 15 +
 rtl/alu_sequencer_rr_arbiter2.sv | 15 +
 rtl/alu_sequencer.sv | 101 ++++++++++
 tb/tb_alu_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// alu_sequencer_pkg: opcodes, FSM states and opcode decode shared by the sequencer and the ALU.
package alu_sequencer_pkg;
  localparam logic [3:0] ADD = 4'd0;
  localparam logic [3:0] SUB = 4'd1;
  localparam logic [3:0] AND = 4'd2;
  localparam logic [3:0] OR  = 4'd3;
  localparam logic [3:0] XOR = 4'd4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  function automatic logic is_op(input logic [3:0] m);
    return m <= XOR;
  endfunction
  function automatic logic is_arith(input logic [3:0] m);
    return m == ADD || m == SUB;
  endfunction
endpackage

// File: rtl/alu_sequencer_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant; the pointer flips to the other requester on every grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr;
  assign gnt[0] = en & req[0] & (~req[1] | ~ptr);
  assign gnt[1] = en & req[1] & (~req[0] | ptr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[0];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: arbitrates two requesters onto one external ALU, one operation in flight at a time.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int N = 8,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic         req1_valid,
  output logic         req0_ready,
  output logic         req1_ready,
  input  logic [3:0]   req0_mode,
  input  logic [3:0]   req1_mode,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_data,
  output logic         rsp_zero,
  output logic         rsp_carry,
  output logic         rsp_err,
  output logic         alu_enable,
  output logic [3:0]   alu_mode,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_out,
  input  logic         alu_carry
);
  localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0] gnt;
  logic acc, sel, last;
  logic [3:0] sel_mode;
  // Gating with rst_n keeps ready low while reset is asserted.
  rr_arbiter2 u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (rst_n && state == IDLE),
    .req  ({req1_valid, req0_valid}),
    .gnt  (gnt)
  );
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign acc = |gnt;
  assign sel = gnt[1];
  assign sel_mode = sel ? req1_mode : req0_mode;
  assign last = state == WAIT && cnt == '0;
  assign alu_enable = state == ISSUE;
  assign rsp_valid = state == RESP;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = acc ? (is_op(sel_mode) ? ISSUE : RESP) : IDLE;
      ISSUE: state_nxt = WAIT;
      WAIT:  state_nxt = last ? RESP : WAIT;
      RESP:  state_nxt = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt       <= '0;
      alu_mode  <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else begin
      if (acc) begin
        alu_mode <= sel_mode;
        alu_a    <= sel ? req1_a : req0_a;
        alu_b    <= sel ? req1_b : req0_b;
        rsp_id   <= sel;
        if (!is_op(sel_mode)) begin
          rsp_data  <= '0;
          rsp_zero  <= 1'b0;
          rsp_carry <= 1'b0;
          rsp_err   <= 1'b1;
        end
      end
      if (state == ISSUE) cnt <= CW'(ALU_LAT - 1);
      else if (state == WAIT) cnt <= cnt - CW'(1);
      if (last) begin
        rsp_data  <= alu_out;
        rsp_zero  <= alu_out == '0;
        rsp_carry <= is_arith(alu_mode) & alu_carry;
        rsp_err   <= 1'b0;
      end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vector table plus arbitration, backpressure and reset sequences.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;
  localparam int N = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [3:0] req0_mode = 0, req1_mode = 0, alu_mode;
  logic [N-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic rsp_valid, rsp_ready = 1, rsp_id, rsp_zero, rsp_carry, rsp_err;
  logic [N-1:0] rsp_data, alu_a, alu_b;
  logic [N-1:0] alu_out = 0;
  logic alu_carry = 0, alu_enable;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  alu_sequencer #(.N(N), .ALU_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_mode(req0_mode), .req1_mode(req1_mode),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_enable(alu_enable), .alu_mode(alu_mode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );
  // One-cycle ALU; carry is forced high on logic ops so masking in the sequencer is observable.
  always @(posedge clk)
    if (alu_enable)
      case (alu_mode)
        ADD: {alu_carry, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
        SUB: {alu_carry, alu_out} <= {1'b0, alu_a} - {1'b0, alu_b};
        AND: {alu_carry, alu_out} <= {1'b1, alu_a & alu_b};
        OR:  {alu_carry, alu_out} <= {1'b1, alu_a | alu_b};
        XOR: {alu_carry, alu_out} <= {1'b1, alu_a ^ alu_b};
        default: {alu_carry, alu_out} <= {1'b1, 8'hEE};
      endcase
  typedef struct {
    logic id;
    logic [3:0] mode;
    logic [N-1:0] a, b, data;
    logic zero, carry, err;
  } vec_t;
  vec_t vecs[9];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input logic id, input logic [3:0] m, input logic [N-1:0] a, input logic [N-1:0] b);
    if (id) begin
      req1_valid = 1; req1_mode = m; req1_a = a; req1_b = b;
    end else begin
      req0_valid = 1; req0_mode = m; req0_a = a; req0_b = b;
    end
  endtask
  task automatic run_op(input vec_t v);
    req0_valid = 0;
    req1_valid = 0;
    set_req(v.id, v.mode, v.a, v.b);
    #1;
    chk("ready_granted", v.id ? req1_ready : req0_ready, 1);
    chk("ready_other", v.id ? req0_ready : req1_ready, 0);
    tick;
    req0_valid = 0;
    req1_valid = 0;
    if (v.err) chk("err_no_issue", alu_enable, 0);
    else begin
      chk("issue_en", alu_enable, 1);
      chk("issue_mode", alu_mode, v.mode);
      chk("issue_a", alu_a, v.a);
      chk("issue_b", alu_b, v.b);
      tick;
      chk("wait_en", alu_enable, 0);
      chk("wait_mode", alu_mode, v.mode);
      chk("wait_rsp", rsp_valid, 0);
      tick;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_id", rsp_id, v.id);
    chk("rsp_data", rsp_data, v.data);
    chk("rsp_zero", rsp_zero, v.zero);
    chk("rsp_carry", rsp_carry, v.carry);
    chk("rsp_err", rsp_err, v.err);
    chk("rsp_en", alu_enable, 0);
    tick;
    chk("rsp_done", rsp_valid, 0);
  endtask
  initial begin
    int order[$];
    logic prev_en;
    vecs[0] = '{0, ADD,   8'hF0, 8'h20, 8'h10, 0, 1, 0};
    vecs[1] = '{1, SUB,   8'h05, 8'h05, 8'h00, 1, 0, 0};
    vecs[2] = '{0, XOR,   8'hAA, 8'h55, 8'hFF, 0, 0, 0};
    vecs[3] = '{1, AND,   8'hF0, 8'h0F, 8'h00, 1, 0, 0};
    vecs[4] = '{0, OR,    8'h12, 8'h21, 8'h33, 0, 0, 0};
    vecs[5] = '{1, SUB,   8'h03, 8'h05, 8'hFE, 0, 1, 0};
    vecs[6] = '{0, 4'hF,  8'h12, 8'h34, 8'h00, 0, 0, 1};
    vecs[7] = '{1, ADD,   8'h7F, 8'h01, 8'h80, 0, 0, 0};
    vecs[8] = '{0, 4'h5,  8'h00, 8'h00, 8'h00, 0, 0, 1};
    set_req(0, ADD, 8'h01, 8'h01);
    set_req(1, ADD, 8'h02, 8'h02);
    #12;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu_enable", alu_enable, 0);
    chk("rst_alu_a", alu_a, 0);
    tick;
    rst_n = 1;
    #1;
    prev_en = 0;
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      if (req0_valid && req0_ready) order.push_back(0);
      if (req1_valid && req1_ready) order.push_back(1);
      chk("ready_onehot", req0_ready & req1_ready, 0);
      chk("en_one_cycle", prev_en & alu_enable, 0);
      prev_en = alu_enable;
      tick;
    end
    req0_valid = 0;
    req1_valid = 0;
    chk("rr_accepts", order.size(), 4);
    for (int k = 0; k < order.size(); k++) chk("rr_order", order[k], k % 2);
    repeat (4) begin
      chk("en_one_cycle", prev_en & alu_enable, 0);
      prev_en = alu_enable;
      tick;
    end
    chk("drained", rsp_valid, 0);
    for (int i = 0; i < 9; i++) run_op(vecs[i]);
    rsp_ready = 0;
    set_req(0, ADD, 8'h01, 8'h02);
    #1;
    chk("bp_ready0", req0_ready, 1);
    tick;
    req0_valid = 0;
    set_req(1, AND, 8'h3C, 8'h0F);
    chk("bp_busy_issue", req1_ready, 0);
    tick;
    chk("bp_busy_wait", req1_ready, 0);
    tick;
    repeat (5) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 8'h03);
      chk("bp_id", rsp_id, 0);
      chk("bp_err", rsp_err, 0);
      chk("bp_ready0", req0_ready, 0);
      chk("bp_ready1", req1_ready, 0);
      tick;
    end
    rsp_ready = 1;
    #1;
    chk("bp_hs_ready1", req1_ready, 0);
    tick;
    chk("bp_after_valid", rsp_valid, 0);
    chk("bp_after_ready1", req1_ready, 1);
    tick;
    req1_valid = 0;
    tick;
    tick;
    chk("bp2_valid", rsp_valid, 1);
    chk("bp2_id", rsp_id, 1);
    chk("bp2_data", rsp_data, 8'h0C);
    chk("bp2_carry", rsp_carry, 0);
    tick;
    set_req(0, ADD, 8'h11, 8'h22);
    #1;
    tick;
    req0_valid = 0;
    tick;
    rst_n = 0;
    set_req(0, ADD, 8'h11, 8'h22);
    set_req(1, SUB, 8'h09, 8'h01);
    #1;
    chk("arst_enable", alu_enable, 0);
    chk("arst_mode", alu_mode, 0);
    chk("arst_a", alu_a, 0);
    chk("arst_b", alu_b, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_ready0", req0_ready, 0);
    chk("arst_ready1", req1_ready, 0);
    tick;
    rst_n = 1;
    #1;
    chk("arst_no_rsp", rsp_valid, 0);
    chk("arst_grant0", req0_ready, 1);
    chk("arst_grant1", req1_ready, 0);
    tick;
    req0_valid = 0;
    req1_valid = 0;
    tick;
    tick;
    chk("arst_rsp_valid2", rsp_valid, 1);
    chk("arst_rsp_id", rsp_id, 0);
    chk("arst_rsp_data", rsp_data, 8'h33);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
